// File: rtl/fft4_pkg.sv
// Shared types and constants for the 4-point FFT sequencer: FSM states,
// integer-encoded twiddles and the bit-reversed output order.
package fft4_pkg;

  typedef enum logic [2:0] {
    LOAD,
    BF0,
    BF1,
    BF2,
    BF3,
    UNLOAD
  } fft4_state_t;

  localparam int N_POINTS      = 4;
  localparam int DEFAULT_WIDTH = 32;

  // Twiddle words for an arbitrary packed width; callers cast to their WIDTH.
  function automatic logic [63:0] w_one_word(input int width);
    return 64'(1) << (width / 2);
  endfunction

  function automatic logic [63:0] w_neg_j_word(input int width);
    return (64'(1) << (width / 2)) - 64'(1);
  endfunction

  localparam logic [DEFAULT_WIDTH-1:0] W_ONE   = DEFAULT_WIDTH'(w_one_word(DEFAULT_WIDTH));
  localparam logic [DEFAULT_WIDTH-1:0] W_NEG_J = DEFAULT_WIDTH'(w_neg_j_word(DEFAULT_WIDTH));

  // After in-place DIT the bins sit bit-reversed: slot order {0,2,1,3}.
  localparam logic [7:0] OUT_ORDER = {2'd3, 2'd1, 2'd2, 2'd0};

  function automatic logic [1:0] out_map(input logic [1:0] idx);
    return OUT_ORDER[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/fft4_sched.sv
// Sequencer for a 4-point radix-2 DIT FFT: loads four samples, drives an
// external shared butterfly for four cycles in place, then streams X0..X3.
module fft4_sched
  import fft4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [WIDTH-1:0] bf_a,
  output logic [WIDTH-1:0] bf_b,
  output logic [WIDTH-1:0] bf_w,
  input  logic [WIDTH-1:0] bf_out0,
  input  logic [WIDTH-1:0] bf_out1,
  output logic             busy
);

  localparam logic [WIDTH-1:0] TW_ONE   = WIDTH'(w_one_word(WIDTH));
  localparam logic [WIDTH-1:0] TW_NEG_J = WIDTH'(w_neg_j_word(WIDTH));
  localparam logic [1:0]       LAST_IDX = 2'(N_POINTS - 1);

  fft4_state_t      state_reg, state_next;
  logic [1:0]       cnt_reg;
  logic [WIDTH-1:0] buf_reg  [N_POINTS];
  logic [WIDTH-1:0] buf_next [N_POINTS];

  logic       load_fire, unload_fire;
  logic       bf_en;
  logic [1:0] idx_a, idx_b;

  assign load_fire   = (state_reg == LOAD) && in_valid;
  assign unload_fire = (state_reg == UNLOAD) && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (load_fire && cnt_reg == LAST_IDX) state_next = BF0;
      BF0:     state_next = BF1;
      BF1:     state_next = BF2;
      BF2:     state_next = BF3;
      BF3:     state_next = UNLOAD;
      UNLOAD:  if (unload_fire && cnt_reg == LAST_IDX) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b1;
    bf_en     = 1'b0;
    idx_a     = 2'd0;
    idx_b     = 2'd0;
    bf_a      = '0;
    bf_b      = '0;
    bf_w      = '0;
    case (state_reg)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      BF0: begin
        bf_en = 1'b1;
        idx_a = 2'd0;
        idx_b = 2'd2;
        bf_w  = TW_ONE;
      end
      BF1: begin
        bf_en = 1'b1;
        idx_a = 2'd1;
        idx_b = 2'd3;
        bf_w  = TW_ONE;
      end
      BF2: begin
        bf_en = 1'b1;
        idx_a = 2'd0;
        idx_b = 2'd1;
        bf_w  = TW_ONE;
      end
      BF3: begin
        bf_en = 1'b1;
        idx_a = 2'd2;
        idx_b = 2'd3;
        bf_w  = TW_NEG_J;
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_last  = (cnt_reg == LAST_IDX);
        out_data  = buf_reg[out_map(cnt_reg)];
      end
      default: begin
        busy = 1'b1;
      end
    endcase
    if (bf_en) begin
      bf_a = buf_reg[idx_a];
      bf_b = buf_reg[idx_b];
    end
  end

  // cnt wraps 3 -> 0 on the fourth transfer, so it is clear on every state exit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load_fire || unload_fire) begin
      cnt_reg <= cnt_reg + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_POINTS; gi++) begin : g_slot
      localparam logic [1:0] SLOT = 2'(gi);
      assign buf_next[gi] = (load_fire && cnt_reg == SLOT) ? in_data :
                            (bf_en && idx_a == SLOT)       ? bf_out0 :
                            (bf_en && idx_b == SLOT)       ? bf_out1 :
                                                             buf_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_reg <= '{default: '0};
    end else begin
      buf_reg <= buf_next;
    end
  end

endmodule

// File: tb/tb_fft4_sched.sv
// Bench for fft4_sched: plays the parent role with a behavioural butterfly and
// checks every bin against a direct 4-point DFT held in a scoreboard queue.
module tb_fft4_sched;

  typedef logic [31:0] frame_t [4];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_last, busy;
  logic [31:0] out_data, bf_a, bf_b, bf_w, bf_out0, bf_out1;

  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int          accept_cyc = 0;
  int          first_accept_cyc = 0;
  logic [31:0] exp_q [$];
  frame_t      ramp, impulse, imag, ovf;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] cmul(input logic [31:0] b, input logic [31:0] w);
    logic signed [15:0] br, bi, wr, wi;
    logic signed [31:0] re, im;
    br = b[31:16]; bi = b[15:0]; wr = w[31:16]; wi = w[15:0];
    re = br * wr - bi * wi;
    im = br * wi + bi * wr;
    return {re[15:0], im[15:0]};
  endfunction

  function automatic logic [31:0] cadd(input logic [31:0] a, input logic [31:0] b);
    return {a[31:16] + b[31:16], a[15:0] + b[15:0]};
  endfunction

  function automatic logic [31:0] csub(input logic [31:0] a, input logic [31:0] b);
    return {a[31:16] - b[31:16], a[15:0] - b[15:0]};
  endfunction

  assign bf_out0 = cadd(bf_a, cmul(bf_b, bf_w));
  assign bf_out1 = csub(bf_a, cmul(bf_b, bf_w));

  fft4_sched #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .bf_a(bf_a), .bf_b(bf_b), .bf_w(bf_w), .bf_out0(bf_out0), .bf_out1(bf_out1),
    .busy(busy)
  );

  // Direct DFT: X[k] = sum x[n] * (-j)^(n*k), 16-bit wrap per part.
  function automatic logic [31:0] dft_bin(input frame_t x, input int k);
    logic [15:0] re, im, xr, xi;
    re = '0; im = '0;
    for (int n = 0; n < 4; n++) begin
      xr = x[n][31:16]; xi = x[n][15:0];
      case ((n * k) % 4)
        0: begin re = re + xr; im = im + xi; end
        1: begin re = re + xi; im = im - xr; end
        2: begin re = re - xr; im = im - xi; end
        default: begin re = re - xi; im = im + xr; end
      endcase
    end
    return {re, im};
  endfunction

  task automatic push_expected(input frame_t x);
    for (int k = 0; k < 4; k++) exp_q.push_back(dft_bin(x, k));
  endtask

  task automatic send_frame(input frame_t x, input int nsamp, input bit rnd);
    bit done;
    int guard;
    for (int n = 0; n < nsamp; n++) begin
      done = 1'b0; guard = 0;
      while (!done && guard < 300) begin
        @(negedge clk);
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = x[n];
        #1;
        checks++;
        if (in_ready && out_valid) $display("FAIL excl_in: in_ready=%b out_valid=%b required not both", in_ready, out_valid);
        else passes++;
        if (in_valid && in_ready) done = 1'b1;
        guard++;
      end
      if (!done) begin
        checks++;
        $display("FAIL send_timeout: sample %0d not accepted, in_ready=%b required 1", n, in_ready);
      end else begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        accept_cyc = cyc;
        if (n == 0) first_accept_cyc = cyc;
      end
    end
  endtask

  task automatic recv_frame(input int n, input bit rnd, input bit chk_lat, input string tag);
    int k, guard;
    bit seen, stalled, held_l;
    logic [31:0] held_d, expv;
    k = 0; guard = 0; seen = 1'b0; stalled = 1'b0; held_l = 1'b0; held_d = '0;
    while (k < n && guard < 400) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      guard++;
      checks++;
      if (in_ready && out_valid) $display("FAIL %s excl_out: in_ready=%b out_valid=%b required not both", tag, in_ready, out_valid);
      else passes++;
      if (out_valid) begin
        if (!seen && chk_lat) begin
          checks++;
          if (cyc - accept_cyc !== 4) $display("FAIL %s latency_valid: got %0d edges required 4", tag, cyc - accept_cyc);
          else passes++;
        end
        seen = 1'b1;
        if (stalled) begin
          checks++;
          if (out_data !== held_d || out_last !== held_l)
            $display("FAIL %s stall_hold: out_data=%h last=%b required %h last=%b", tag, out_data, out_last, held_d, held_l);
          else passes++;
        end
        if (out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard_empty: got %h with no expected value", tag, out_data);
          end else begin
            expv = exp_q.pop_front();
            if (out_data !== expv) $display("FAIL %s X%0d: got %h required %h", tag, k, out_data, expv);
            else passes++;
          end
          checks++;
          if (out_last !== (k == 3)) $display("FAIL %s last_X%0d: got %b required %b", tag, k, out_last, (k == 3));
          else passes++;
          $display("%s: X%0d = %h last=%b", tag, k, out_data, out_last);
          stalled = 1'b0;
          @(posedge clk);
          k++;
        end else begin
          stalled = 1'b1;
          held_d = out_data;
          held_l = out_last;
        end
      end
    end
    #1;
    out_ready = 1'b0;
    if (k < n) begin
      checks++;
      $display("FAIL %s recv_timeout: got %0d outputs required %0d", tag, k, n);
    end else if (chk_lat) begin
      checks++;
      if (cyc - accept_cyc !== 8) $display("FAIL %s latency_last: X3 at edge +%0d required +8", tag, cyc - accept_cyc);
      else passes++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, busy} !== 4'b1000)
      $display("FAIL reset_ctrl: rdy/vld/last/busy=%b required 1000", {in_ready, out_valid, out_last, busy});
    else passes++;
    checks++;
    if ({bf_a, bf_b, bf_w, out_data} !== '0)
      $display("FAIL reset_data: bf_a=%h bf_b=%h bf_w=%h out_data=%h required 0", bf_a, bf_b, bf_w, out_data);
    else passes++;
    rst_n = 1'b1;
    $display("reset: in_ready=%b busy=%b", in_ready, busy);
  endtask

  task automatic test_ramp();
    push_expected(ramp);
    send_frame(ramp, 4, 1'b0);
    recv_frame(4, 1'b0, 1'b1, "ramp");
  endtask

  task automatic test_back_to_back();
    int f1;
    push_expected(impulse);
    send_frame(impulse, 4, 1'b0);
    f1 = first_accept_cyc;
    recv_frame(4, 1'b0, 1'b1, "impulse_a");
    push_expected(impulse);
    send_frame(impulse, 4, 1'b0);
    checks++;
    if (first_accept_cyc - f1 !== 12) $display("FAIL frame_period: got %0d cycles required 12", first_accept_cyc - f1);
    else passes++;
    recv_frame(4, 1'b0, 1'b1, "impulse_b");
  endtask

  task automatic test_imag();
    push_expected(imag);
    send_frame(imag, 4, 1'b0);
    checks++;
    if (bf_w !== 32'h0001_0000) $display("FAIL bf0_w: got %h required 00010000", bf_w);
    else passes++;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (bf_w !== 32'h0000_FFFF || busy !== 1'b1) $display("FAIL bf3_w: got %h busy=%b required 0000ffff busy=1", bf_w, busy);
    else passes++;
    recv_frame(4, 1'b0, 1'b0, "imag");
  endtask

  task automatic test_backpressure();
    push_expected(ramp);
    send_frame(ramp, 4, 1'b1);
    recv_frame(4, 1'b1, 1'b0, "backpressure");
  endtask

  task automatic test_reset_mid(input int where);
    case (where)
      0: send_frame(ramp, 2, 1'b0);
      1: begin
        send_frame(ramp, 4, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
      end
      default: begin
        push_expected(ramp);
        send_frame(ramp, 4, 1'b0);
        recv_frame(2, 1'b0, 1'b0, "pre_reset");
      end
    endcase
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    checks++;
    if ({in_ready, out_valid, out_last, busy} !== 4'b1000)
      $display("FAIL midreset%0d_ctrl: rdy/vld/last/busy=%b required 1000", where, {in_ready, out_valid, out_last, busy});
    else passes++;
    checks++;
    if ({bf_a, bf_b, bf_w, out_data} !== '0)
      $display("FAIL midreset%0d_data: bf_a=%h bf_b=%h bf_w=%h out_data=%h required 0", where, bf_a, bf_b, bf_w, out_data);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    $display("midreset%0d: reset applied, resending ramp", where);
    push_expected(ramp);
    send_frame(ramp, 4, 1'b0);
    recv_frame(4, 1'b0, 1'b1, "after_reset");
  endtask

  task automatic test_overflow();
    push_expected(ovf);
    send_frame(ovf, 4, 1'b0);
    recv_frame(4, 1'b0, 1'b0, "overflow");
  endtask

  initial begin
    ramp    = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
    impulse = '{32'h0005_0000, 32'h0, 32'h0, 32'h0};
    imag    = '{32'h0000_0001, 32'h0, 32'h0, 32'h0};
    ovf     = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
    test_reset();
    test_ramp();
    test_back_to_back();
    test_imag();
    test_backpressure();
    for (int w = 0; w < 3; w++) test_reset_mid(w);
    test_overflow();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/fft4_sched.md
# fft4_sched

Sequencer for a 4-point radix-2 DIT FFT built on one shared combinational `butterfly` instance. It accepts four packed complex samples over a valid/ready stream and buffers them. It then issues the four butterfly operations, two stages of two, one per cycle, and writes results back in place. It finally streams X0..X3 out in natural order. It sits between the sample source and the spectrum consumer; the parent instantiates `butterfly` next to it and wires the `bf_*` ports.

## Interface
- `WIDTH`, 32, packed complex word width: real part in [WIDTH-1:WIDTH/2], imaginary part in [WIDTH/2-1:0]. Both parts are signed two's complement, integer scaled.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `in_valid` input 1: source has a sample on `in_data`.
- `in_ready` output 1: block accepts a sample this cycle.
- `in_data` input WIDTH: time-domain sample x[n], with n = 0..3 in arrival order.
- `out_valid` output 1: `out_data` holds a result.
- `out_ready` input 1: consumer takes `out_data` this cycle.
- `out_data` output WIDTH: frequency bin X[k], with k = 0..3 in order.
- `out_last` output 1: high with X[3].
- `bf_a`, `bf_b`, `bf_w` output WIDTH: butterfly operands A, B and twiddle W.
- `bf_out0`, `bf_out1` input WIDTH: butterfly results A+B·W and A−B·W, both combinational.
- `busy` output 1: high in any state other than LOAD.

## Operation
- Storage is four WIDTH-bit registers buf[0..3], plus a 2-bit index cnt.
- Twiddles use integer encoding. W_ONE = {+1, 0}. W_NEG_J = {0, −1}.
- State LOAD:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, buf[cnt] ← in_data and cnt++.
  - On the 4th accept (cnt==3), clear cnt and go to BF0.
- State BF0: A=buf0, B=buf2, W=W_ONE. Capture buf0←out0, buf2←out1. Go to BF1.
- State BF1: A=buf1, B=buf3, W=W_ONE. Capture buf1←out0, buf3←out1. Go to BF2.
- State BF2: A=buf0, B=buf1, W=W_ONE. Capture buf0←out0 (X0), buf1←out1 (X2). Go to BF3.
- State BF3: A=buf2, B=buf3, W=W_NEG_J. Capture buf2←out0 (X1), buf3←out1 (X3). Go to UNLOAD.
- State UNLOAD:
  - `out_valid`=1.
  - `out_data` = buf[map(cnt)], with map = {0,2,1,3}.
  - On `out_valid`&&`out_ready`, cnt++.
  - `out_last` = (cnt==3).
  - On the 4th handshake, clear cnt and go to LOAD.
- Outside the BF states, `bf_a`/`bf_b`/`bf_w` are driven to 0.
- Arithmetic is entirely inside `butterfly`. The block captures results bit-exact with no scaling, saturation or rounding, so overflow wraps modulo 2^(WIDTH/2) per part.
- `in_ready` and `out_valid` are never high in the same cycle. There is no overlap between frames.
- `out_data` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset (`rst_n`=0 at a rising edge): state=LOAD, cnt=0, buf[*]=0.
- Output values after reset: `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0, `bf_*`=0, `out_data`=0.
- Reset applies from any state, including mid-LOAD, a BF state or mid-UNLOAD. The partial frame is discarded, no output is produced, and the next accepted sample is x[0].
- Latency: the last input accepted at edge t gives BF0..BF3 during cycles t+1..t+4. `out_valid` rises in cycle t+5. With `out_ready` held high, X3 leaves at edge t+8.
- Minimum frame period is 4 + 4 + 4 = 12 cycles.
- `in_valid` gaps stall LOAD indefinitely. `out_ready` gaps stall UNLOAD indefinitely. BF states never stall.
- `in_valid` seen outside LOAD is ignored. The source must hold the sample until `in_ready`.

## Structure
- Package `fft4_pkg` contains:
  - the state enum `fft4_state_t` (LOAD, BF0, BF1, BF2, BF3, UNLOAD);
  - localparams `N_POINTS`=4, `W_ONE` and `W_NEG_J` as functions of WIDTH;
  - the output order map {0,2,1,3}.
- No sub-module. The existing `butterfly` is instantiated by the parent, not inside this block. The block itself is one FSM, a counter and the register file.

## Test plan
- Ramp: x = {1,0},{2,0},{3,0},{4,0} with both streams always ready → X = {10,0},{−2,+2},{−2,0},{−2,−2}. X1 = 32'hFFFE_0002. `out_last` is high only on X3. `out_valid` rises 5 cycles after the 4th accept.
- Impulse: x = {5,0},{0,0},{0,0},{0,0} → all four X = {5,0}. Two back-to-back frames are 12 cycles apart.
- Imaginary input: x = {0,1},{0,0},{0,0},{0,0} → all X = {0,1}. Also check that BF3 drives `bf_w` = 32'h0000_FFFF.
- Backpressure: random `in_valid` and `out_ready` at 50% with the ramp frame → identical results. `out_data` is stable during stalls. `in_ready` is never high while `out_valid` is high.
- Reset mid-frame:
  - Assert `rst_n`=0 for one cycle after 2 accepted inputs → all outputs take their reset values. The next frame (ramp) gives the correct X.
  - Repeat with reset during BF2 and during UNLOAD after X1 → same requirements.
- Overflow wrap: x = four {16'h4000,0} → X0 real wraps to 0, and X1..X3 = 0.
